lcd_spi_stream: RTL and testbench

Parametrised ST7789-class SPI display driver, the successor to the fixed 240x135 panel driver. It runs the power-up and init sequence, then streams RGB565 frames from a pixel memory. Window size, panel offsets, SPI clock rate, startup delays and memory read latency are generics. New behaviour over the previous driver:
- divided SPI clock;
- per-frame window re-addressing;
- frame handshakes;
- enable gating.

---
 rtl/lcd_spi_stream.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_lcd_spi_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_stream.sv
// ST7789-class SPI display driver: power-up, init table, then per-frame
// window header and back-to-back RGB565 pixel stream from a pixel memory.
module lcd_spi_stream #(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned H_RES   = 240,
    parameter int unsigned V_RES   = 135,
    parameter int unsigned COL_OFS = 40,
    parameter int unsigned ROW_OFS = 53,
    parameter int unsigned ADR_W   = 15,
    parameter int unsigned RD_LAT  = 1,
    parameter int unsigned T_RST   = 2700000,
    parameter int unsigned T_PREP  = 5400000,
    parameter int unsigned T_SLEEP = 3240000,
    parameter logic [7:0]  MADCTL  = 8'h70
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             lcd_resetn,
    output logic             lcd_clk,
    output logic             lcd_cs,
    output logic             lcd_rs,
    output logic             lcd_data,
    output logic [ADR_W-1:0] pixel_adr,
    input  logic [15:0]      pixel_in,
    output logic             ready,
    output logic             frame_start,
    output logic             frame_done
);

    localparam int unsigned NPIX  = H_RES * V_RES;
    localparam int unsigned T_MX1 = (T_RST > T_PREP) ? T_RST : T_PREP;
    localparam int unsigned T_MAX = (T_MX1 > T_SLEEP) ? T_MX1 : T_SLEEP;
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned LAT_W = RD_LAT + 1;

    localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);
    localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(NPIX - 1);
    localparam logic [15:0]      COL_S    = 16'(COL_OFS);
    localparam logic [15:0]      COL_E    = 16'(COL_OFS + H_RES - 1);
    localparam logic [15:0]      ROW_S    = 16'(ROW_OFS);
    localparam logic [15:0]      ROW_E    = 16'(ROW_OFS + V_RES - 1);

    typedef enum logic [2:0] {
        RST_HOLD, PREP, WAKE, SLEEP_WAIT, INIT, IDLE, HDR, PIXELS
    } state_t;

    // Bit 8 is the D/C level for the byte: 0 = command, 1 = parameter.
    function automatic logic [8:0] init_entry(input logic [5:0] i);
        logic [8:0] e;
        case (i)
            6'd0:  e = 9'h036;  6'd1:  e = {1'b1, MADCTL};
            6'd2:  e = 9'h03A;  6'd3:  e = 9'h105;
            6'd4:  e = 9'h0B2;  6'd5:  e = 9'h10C;  6'd6:  e = 9'h10C;
            6'd7:  e = 9'h100;  6'd8:  e = 9'h133;  6'd9:  e = 9'h133;
            6'd10: e = 9'h0B7;  6'd11: e = 9'h135;
            6'd12: e = 9'h0BB;  6'd13: e = 9'h119;
            6'd14: e = 9'h0C0;  6'd15: e = 9'h12C;
            6'd16: e = 9'h0C2;  6'd17: e = 9'h101;
            6'd18: e = 9'h0C3;  6'd19: e = 9'h112;
            6'd20: e = 9'h0C4;  6'd21: e = 9'h120;
            6'd22: e = 9'h0C6;  6'd23: e = 9'h10F;
            6'd24: e = 9'h0D0;  6'd25: e = 9'h1A4;  6'd26: e = 9'h1A1;
            6'd27: e = 9'h0E0;
            6'd28: e = 9'h1D0;  6'd29: e = 9'h104;  6'd30: e = 9'h10D;
            6'd31: e = 9'h111;  6'd32: e = 9'h113;  6'd33: e = 9'h12B;
            6'd34: e = 9'h13F;  6'd35: e = 9'h154;  6'd36: e = 9'h14C;
            6'd37: e = 9'h118;  6'd38: e = 9'h10D;  6'd39: e = 9'h10B;
            6'd40: e = 9'h11F;  6'd41: e = 9'h123;
            6'd42: e = 9'h0E1;
            6'd43: e = 9'h1D0;  6'd44: e = 9'h104;  6'd45: e = 9'h10C;
            6'd46: e = 9'h111;  6'd47: e = 9'h113;  6'd48: e = 9'h12C;
            6'd49: e = 9'h13F;  6'd50: e = 9'h144;  6'd51: e = 9'h151;
            6'd52: e = 9'h12F;  6'd53: e = 9'h11F;  6'd54: e = 9'h11F;
            6'd55: e = 9'h120;  6'd56: e = 9'h123;
            6'd57: e = 9'h021;  6'd58: e = 9'h029;
            default: e = 9'h000;
        endcase
        return e;
    endfunction

    function automatic logic [8:0] hdr_entry(input logic [3:0] i);
        logic [8:0] e;
        case (i)
            4'd0:  e = 9'h02A;
            4'd1:  e = {1'b1, COL_S[15:8]};
            4'd2:  e = {1'b1, COL_S[7:0]};
            4'd3:  e = {1'b1, COL_E[15:8]};
            4'd4:  e = {1'b1, COL_E[7:0]};
            4'd5:  e = 9'h02B;
            4'd6:  e = {1'b1, ROW_S[15:8]};
            4'd7:  e = {1'b1, ROW_S[7:0]};
            4'd8:  e = {1'b1, ROW_E[15:8]};
            4'd9:  e = {1'b1, ROW_E[7:0]};
            4'd10: e = 9'h02C;
            default: e = 9'h000;
        endcase
        return e;
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         idx;
    logic [ADR_W-1:0]   pix_cnt;
    logic               spi_busy;
    logic [15:0]        shreg;
    logic [3:0]         bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   gap_cnt;
    logic [15:0]        pf_data;
    logic [LAT_W-1:0]   iss;

    logic               spi_tick, spi_last, spi_free;
    logic [8:0]         init_e, hdr_e;
    logic               cnt_clr, resetn_set;
    logic               ld, ld_16, ld_rs;
    logic [15:0]        ld_word;
    logic               idx_clr, idx_inc;
    logic               pix_first, pix_next, frame_end, issue0, pf_issue;

    assign spi_tick = spi_busy && (div_cnt == DIV_END);
    assign spi_last = spi_tick && lcd_clk && (bit_cnt == 4'd0);
    assign spi_free = !spi_busy && (gap_cnt == '0);
    assign init_e   = init_entry(idx);
    assign hdr_e    = hdr_entry(idx[3:0]);

    always_ff @(posedge clk) begin
        if (reset) state <= RST_HOLD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cnt_clr    = 1'b0;
        resetn_set = 1'b0;
        ld         = 1'b0;
        ld_16      = 1'b0;
        ld_rs      = 1'b0;
        ld_word    = '0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        pix_first  = 1'b0;
        pix_next   = 1'b0;
        frame_end  = 1'b0;
        issue0     = 1'b0;
        case (state)
            RST_HOLD: if (cnt == CNT_W'(T_RST - 1)) begin
                state_nxt  = PREP;
                cnt_clr    = 1'b1;
                resetn_set = 1'b1;
            end
            // The wake command launches on the same edge the delay expires.
            PREP: if (cnt == CNT_W'(T_PREP - 1)) begin
                state_nxt = WAKE;
                ld        = 1'b1;
                ld_word   = 16'h0011;
            end
            WAKE: if (spi_last) begin
                state_nxt = SLEEP_WAIT;
                cnt_clr   = 1'b1;
            end
            SLEEP_WAIT: if (cnt == CNT_W'(T_SLEEP - 1)) begin
                state_nxt = INIT;
                idx_clr   = 1'b1;
            end
            INIT: if (spi_free) begin
                if (idx == 6'd59) begin
                    state_nxt = IDLE;
                end else begin
                    ld      = 1'b1;
                    ld_rs   = init_e[8];
                    ld_word = {8'h00, init_e[7:0]};
                    idx_inc = 1'b1;
                end
            end
            IDLE: if (enable) begin
                state_nxt = HDR;
                idx_clr   = 1'b1;
                issue0    = 1'b1;
            end
            HDR: if (spi_free) begin
                if (idx == 6'd11) begin
                    state_nxt = PIXELS;
                    ld        = 1'b1;
                    ld_16     = 1'b1;
                    ld_rs     = 1'b1;
                    ld_word   = pf_data;
                    pix_first = 1'b1;
                end else begin
                    ld      = 1'b1;
                    ld_rs   = hdr_e[8];
                    ld_word = {8'h00, hdr_e[7:0]};
                    idx_inc = 1'b1;
                end
            end
            PIXELS: if (spi_last) begin
                if (pix_cnt == LAST_ADR) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end else begin
                    ld       = 1'b1;
                    ld_16    = 1'b1;
                    ld_rs    = 1'b1;
                    ld_word  = pf_data;
                    pix_next = 1'b1;
                end
            end
            default: state_nxt = RST_HOLD;
        endcase
        pf_issue = (pix_first || pix_next) && (pixel_adr != LAST_ADR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            pix_cnt     <= '0;
            lcd_resetn  <= 1'b0;
            lcd_cs      <= 1'b1;
            lcd_rs      <= 1'b1;
            lcd_data    <= 1'b1;
            lcd_clk     <= 1'b0;
            pixel_adr   <= '0;
            ready       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            spi_busy    <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            pf_data     <= '0;
            iss         <= '0;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (resetn_set) lcd_resetn <= 1'b1;
            if (idx_clr)      idx <= '0;
            else if (idx_inc) idx <= idx + 6'd1;
            ready       <= (state_nxt == IDLE);
            frame_start <= pix_first;
            frame_done  <= frame_end;

            // A load on the final falling edge chains words with cs held low.
            if (ld) begin
                spi_busy <= 1'b1;
                lcd_cs   <= 1'b0;
                lcd_clk  <= 1'b0;
                lcd_rs   <= ld_rs;
                div_cnt  <= '0;
                gap_cnt  <= '0;
                lcd_data <= ld_16 ? ld_word[15] : ld_word[7];
                shreg    <= ld_16 ? {ld_word[14:0], 1'b0} : {ld_word[6:0], 9'b0};
                bit_cnt  <= ld_16 ? 4'd15 : 4'd7;
            end else if (spi_busy) begin
                if (spi_tick) begin
                    div_cnt <= '0;
                    lcd_clk <= ~lcd_clk;
                    if (lcd_clk) begin
                        if (bit_cnt == 4'd0) begin
                            spi_busy <= 1'b0;
                            lcd_cs   <= 1'b1;
                            gap_cnt  <= DIV_END;
                        end else begin
                            lcd_data <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt - 4'd1;
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - DIV_W'(1);
            end

            if (pix_first)     pix_cnt <= '0;
            else if (pix_next) pix_cnt <= pix_cnt + ADR_W'(1);
            if (frame_end)     pixel_adr <= '0;
            else if (pf_issue) pixel_adr <= pixel_adr + ADR_W'(1);

            // Read data is taken RD_LAT cycles after the address settles.
            iss <= (iss << 1) | LAT_W'(pf_issue || issue0);
            if (iss[RD_LAT]) pf_data <= pixel_in;
        end
    end

endmodule

// File: tb/tb_lcd_spi_stream.sv
// Self-checking bench for lcd_spi_stream: SPI byte decoder against a scoreboard
// of expected bytes, plus startup, frame-length, enable and reset sequences.
module tb_lcd_spi_stream;

    localparam int unsigned CLK_DIV   = 2;
    localparam int unsigned H_RES     = 4;
    localparam int unsigned V_RES     = 2;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned T_RST     = 4;
    localparam int unsigned T_PREP    = 6;
    localparam int unsigned T_SLEEP   = 3;
    localparam int unsigned NPIX      = H_RES * V_RES;
    localparam int unsigned FRAME_CYC = 32 * CLK_DIV * NPIX;

    localparam logic [8:0] INIT_TAB [59] = '{
        9'h036, 9'h170, 9'h03A, 9'h105,
        9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
        9'h0B7, 9'h135, 9'h0BB, 9'h119, 9'h0C0, 9'h12C,
        9'h0C2, 9'h101, 9'h0C3, 9'h112, 9'h0C4, 9'h120,
        9'h0C6, 9'h10F, 9'h0D0, 9'h1A4, 9'h1A1,
        9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F,
        9'h154, 9'h14C, 9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
        9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F,
        9'h144, 9'h151, 9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
        9'h021, 9'h029
    };
    localparam logic [8:0] HDR_TAB [11] = '{
        9'h02A, 9'h100, 9'h128, 9'h100, 9'h12B,
        9'h02B, 9'h100, 9'h135, 9'h100, 9'h136, 9'h02C
    };

    typedef struct packed {
        logic       rs;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        string       name;
        int unsigned drop_after;
        int unsigned exp_low;
        logic        exp_ready;
    } frm_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        lcd_resetn, lcd_clk, lcd_cs, lcd_rs, lcd_data;
    logic [14:0] pixel_adr;
    logic [15:0] pixel_in;
    logic        ready, frame_start, frame_done;

    logic [15:0] mem [NPIX];
    logic [15:0] rd_d1, rd_d2;

    sb_t         sb[$];
    sb_t         exp_b;
    frm_t        ftab[3];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned fs_cnt = 0;
    int unsigned fd_cnt = 0;
    int unsigned bitn = 0;
    logic [7:0]  sh = '0;
    logic        brs = 1'b0;
    logic        prev_sclk = 1'b0;
    int unsigned t1, t2;

    lcd_spi_stream #(
        .CLK_DIV(CLK_DIV), .H_RES(H_RES), .V_RES(V_RES),
        .COL_OFS(40), .ROW_OFS(53), .ADR_W(15), .RD_LAT(RD_LAT),
        .T_RST(T_RST), .T_PREP(T_PREP), .T_SLEEP(T_SLEEP), .MADCTL(8'h70)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .lcd_resetn(lcd_resetn), .lcd_clk(lcd_clk), .lcd_cs(lcd_cs),
        .lcd_rs(lcd_rs), .lcd_data(lcd_data), .pixel_adr(pixel_adr),
        .pixel_in(pixel_in), .ready(ready),
        .frame_start(frame_start), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Pixel memory with RD_LAT=2 register stages.
    always @(posedge clk) begin
        rd_d1 <= mem[pixel_adr[2:0]];
        rd_d2 <= rd_d1;
    end
    assign pixel_in = rd_d2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [8:0] e);
        sb.push_back(sb_t'(e));
    endtask

    task automatic push_frame();
        for (int i = 0; i < 11; i++) push(HDR_TAB[i]);
        for (int i = 0; i < int'(NPIX); i++) begin
            push({1'b1, 8'hA5});
            push({1'b1, 8'(i)});
        end
    endtask

    // SPI decoder: sample MOSI on each SCLK rise while cs is low.
    always @(negedge clk) begin
        if (frame_start === 1'b1) fs_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
        if (lcd_cs !== 1'b0) begin
            bitn = 0;
        end else if (lcd_clk === 1'b1 && prev_sclk === 1'b0) begin
            sh  = {sh[6:0], lcd_data};
            brs = lcd_rs;
            bitn++;
            if (bitn == 8) begin
                bitn = 0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spi_unexpected: got rs=%0b byte=%02h expected no byte", brs, sh);
                end else begin
                    exp_b = sb.pop_front();
                    check("spi_byte", {23'd0, brs, sh}, {23'd0, exp_b.rs, exp_b.data});
                end
            end
        end
        prev_sclk = lcd_clk;
    end

    task automatic startup(output int unsigned total);
        int unsigned n, m, k;
        push(9'h011);
        for (int i = 0; i < 59; i++) push(INIT_TAB[i]);
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (lcd_resetn !== 1'b1 && n < 100);
        check("resetn_low_len", n, T_RST);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (lcd_cs !== 1'b0 && m < 100);
        check("prep_to_cs_fall", m, T_PREP);
        k = 0;
        while (ready !== 1'b1 && k < 20000) begin @(posedge clk); #1; k++; end
        check("init_ready", ready, 1);
        check("init_cs_idle", lcd_cs, 1);
        check("init_bytes_left", sb.size(), 0);
        total = n + m + k;
    endtask

    task automatic run_frame(input frm_t f);
        int unsigned n, hi, lo;
        check({f.name, "_ready_idle"}, ready, 1);
        push_frame();
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk); #1;
        check({f.name, "_ready_fall"}, ready, 0);
        n = 0;
        while (frame_start !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
        check({f.name, "_frame_start"}, frame_start, 1);
        check({f.name, "_cs_fall_at_start"}, lcd_cs, 0);
        n = 0;
        hi = 0;
        while (frame_done !== 1'b1 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (n == f.drop_after) enable = 1'b0;
            if (frame_done !== 1'b1 && lcd_cs !== 1'b0) hi++;
        end
        check({f.name, "_stream_len"}, n, f.exp_low);
        check({f.name, "_cs_gaps"}, hi, 0);
        check({f.name, "_cs_rise_at_done"}, lcd_cs, 1);
        check({f.name, "_adr_back_0"}, 32'(pixel_adr), 0);
        lo = 0;
        repeat (200) begin @(posedge clk); #1; if (lcd_cs !== 1'b1) lo++; end
        check({f.name, "_no_new_header"}, lo, 0);
        check({f.name, "_ready_after"}, ready, f.exp_ready);
        check({f.name, "_bytes_left"}, sb.size(), 0);
    endtask

    initial begin
        int unsigned w;
        for (int i = 0; i < int'(NPIX); i++) mem[i] = 16'hA500 + 16'(i);
        ftab[0] = '{"frame_a", 40, FRAME_CYC, 1'b1};
        ftab[1] = '{"frame_b", 500, FRAME_CYC, 1'b1};
        ftab[2] = '{"frame_c", 3, FRAME_CYC, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_resetn", lcd_resetn, 0);
        check("rst_cs", lcd_cs, 1);
        check("rst_rs", lcd_rs, 1);
        check("rst_data", lcd_data, 1);
        check("rst_sclk", lcd_clk, 0);
        check("rst_adr", 32'(pixel_adr), 0);
        check("rst_ready", ready, 0);
        check("rst_fstart", frame_start, 0);
        check("rst_fdone", frame_done, 0);

        startup(t1);
        for (int i = 0; i < 2; i++) run_frame(ftab[i]);

        // Reset pulsed in the middle of a pixel stream.
        push_frame();
        @(negedge clk);
        enable = 1'b1;
        w = 0;
        while (frame_start !== 1'b1 && w < 5000) begin @(posedge clk); #1; w++; end
        check("abort_frame_start", frame_start, 1);
        repeat (100) begin @(posedge clk); #1; end
        @(negedge clk);
        reset = 1'b1;
        enable = 1'b0;
        @(posedge clk); #1;
        check("midrst_cs", lcd_cs, 1);
        check("midrst_resetn", lcd_resetn, 0);
        check("midrst_sclk", lcd_clk, 0);
        check("midrst_rs", lcd_rs, 1);
        check("midrst_data", lcd_data, 1);
        check("midrst_adr", 32'(pixel_adr), 0);
        check("midrst_ready", ready, 0);
        sb.delete();

        startup(t2);
        check("replay_timing", t2, t1);
        run_frame(ftab[2]);
        check("frame_start_count", fs_cnt, 4);
        check("frame_done_count", fd_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
